// File: rtl/hamm_inject_ctrl_pkg.sv
// Shared encodings and widths for the Hamming(7,4) fault-injection sequencer.
package hamm_inject_ctrl_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_FIXED = 2'b01,
        MODE_SWEEP = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/hamm_inject_ctrl_error_inject.sv
// Error injector: inverts codeword bit selected by pos; out-of-range pos leaves the word untouched.
module error_inject
    import hamm_inject_ctrl_pkg::*;
(
    input  logic [CODE_W-1:0] code_in,
    input  logic [2:0]        pos,
    output logic [CODE_W-1:0] code_out
);

    always_comb begin
        code_out = code_in;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            if (pos == 3'(i)) begin
                code_out[i] = ~code_in[i];
            end
        end
    end

endmodule

// File: rtl/hamm_inject_ctrl.sv
// Burst sequencer: accepts codewords, optionally flips one data bit, and emits them
// through a one-deep registered output stage tagged with injection info.
module hamm_inject_ctrl
    import hamm_inject_ctrl_pkg::*;
#(
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_mode,
    input  logic [1:0]         cfg_idx,
    input  logic [3:0]         cfg_period,
    input  logic [BURST_W-1:0] cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_code,
    output logic               out_inj,
    output logic [1:0]         out_idx,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] inj_count
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [IDX_W-1:0]    cfg_idx_q, cfg_idx_d;
    logic [3:0]          period_q, period_d;
    logic [3:0]          p_q, p_d;
    logic [BURST_W-1:0]  len_q, len_d;
    logic [BURST_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]    sweep_q, sweep_d;
    logic [BURST_W-1:0]  inj_count_q, inj_count_d;
    logic                out_valid_q, out_valid_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                out_inj_q, out_inj_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;

    logic                accept;
    logic                out_hs;
    logic                inj_hit;
    logic                p_wrap;
    logic [IDX_W-1:0]    inj_idx;
    logic [CODE_W-1:0]   flipped;

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign p_wrap   = (period_q != '0) && (p_q == period_q - 4'd1);
    assign inj_hit  = ((mode_q == MODE_FIXED) || (mode_q == MODE_SWEEP)) && p_wrap;
    assign inj_idx  = (mode_q == MODE_SWEEP) ? sweep_q : cfg_idx_q;

    // The injector always flips a bit; the inject decision selects between it and the raw word.
    error_inject u_error_inject (
        .code_in  (in_code),
        .pos      ({1'b0, inj_idx}),
        .code_out (flipped)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cfg_idx_d   = cfg_idx_q;
        period_d    = period_q;
        p_d         = p_q;
        len_d       = len_q;
        k_d         = k_q;
        sweep_d     = sweep_q;
        inj_count_d = inj_count_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_inj_d   = out_inj_q;
        out_idx_d   = out_idx_q;

        // abort outranks start and any handshake in the same cycle
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            if (out_hs) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                out_valid_d = 1'b1;
                out_code_d  = inj_hit ? flipped : in_code;
                out_inj_d   = inj_hit;
                out_idx_d   = inj_hit ? inj_idx : '0;
                k_d         = k_q + BURST_W'(1);
                p_d         = p_wrap ? '0 : ((period_q == '0) ? '0 : p_q + 4'd1);
                if (inj_hit) begin
                    sweep_d = sweep_q + IDX_W'(1);
                    if (inj_count_q != '1) begin
                        inj_count_d = inj_count_q + BURST_W'(1);
                    end
                end
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d      = mode_e'(cfg_mode);
                        cfg_idx_d   = cfg_idx;
                        period_d    = cfg_period;
                        len_d       = cfg_len;
                        k_d         = '0;
                        p_d         = '0;
                        sweep_d     = '0;
                        inj_count_d = '0;
                        state_d     = (cfg_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && (k_q + BURST_W'(1) == len_q)) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q || out_hs) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OFF;
            cfg_idx_q   <= '0;
            period_q    <= '0;
            p_q         <= '0;
            len_q       <= '0;
            k_q         <= '0;
            sweep_q     <= '0;
            inj_count_q <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_inj_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cfg_idx_q   <= cfg_idx_d;
            period_q    <= period_d;
            p_q         <= p_d;
            len_q       <= len_d;
            k_q         <= k_d;
            sweep_q     <= sweep_d;
            inj_count_q <= inj_count_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_inj_q   <= out_inj_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_inj   = out_inj_q;
    assign out_idx   = out_idx_q;
    assign inj_count = inj_count_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_hamm_inject_ctrl.sv
// Self-checking bench for hamm_inject_ctrl: word-number based reference model plus
// directed bursts with hand-computed expectations.
module tb_hamm_inject_ctrl;

    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rstn, start, abort, in_valid, out_ready;
    logic [1:0]    cfg_mode, cfg_idx;
    logic [3:0]    cfg_period;
    logic [BW-1:0] cfg_len;
    logic [6:0]    in_code;
    logic          in_ready, out_valid, out_inj, busy, done;
    logic [6:0]    out_code;
    logic [1:0]    out_idx;
    logic [BW-1:0] inj_count;

    hamm_inject_ctrl #(.BURST_W(BW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_idx(cfg_idx), .cfg_period(cfg_period), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_inj(out_inj), .out_idx(out_idx), .busy(busy), .done(done), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: tracks accepted-word number n and derives injection from n directly.
    bit          m_run, m_drain, m_done, m_ov, m_inj;
    int          m_len, m_period, m_mode, m_cidx, m_accepted, m_cnt, m_oidx;
    logic [6:0]  m_code;
    logic [6:0]  code_tab [16];

    always @(posedge clk) begin
        bit hs, acc, new_done, inj;
        int n, idx;
        if (!rstn) begin
            m_run = 0; m_drain = 0; m_done = 0; m_ov = 0; m_inj = 0;
            m_code = '0; m_oidx = 0; m_cnt = 0; m_accepted = 0;
        end else if (abort) begin
            m_run = 0; m_drain = 0; m_done = 0; m_ov = 0;
        end else begin
            hs  = m_ov && out_ready;
            acc = in_valid && m_run && (!m_ov || out_ready);
            new_done = 0;
            if (m_done) begin
                m_done = 0;
            end else if (!m_run && !m_drain && start) begin
                m_mode = int'(cfg_mode); m_cidx = int'(cfg_idx);
                m_period = int'(cfg_period); m_len = int'(cfg_len);
                m_cnt = 0; m_accepted = 0;
                if (m_len == 0) new_done = 1;
                else m_run = 1;
            end else if (m_drain && (!m_ov || hs)) begin
                m_drain = 0;
                new_done = 1;
            end
            if (hs) m_ov = 0;
            if (acc) begin
                m_accepted++;
                n   = m_accepted;
                inj = (m_mode == 1 || m_mode == 2) && m_period != 0 && (n % m_period) == 0;
                idx = (m_mode == 1) ? m_cidx : (((n / m_period) - 1) % 4);
                m_ov   = 1;
                m_inj  = inj;
                m_oidx = inj ? idx : 0;
                m_code = inj ? (in_code ^ (7'd1 << idx)) : in_code;
                if (inj && m_cnt < 255) m_cnt++;
                if (n == m_len) begin
                    m_run = 0;
                    m_drain = 1;
                end
            end
            m_done = new_done;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_run && (!m_ov || out_ready));
            check("out_valid", out_valid, m_ov);
            check("busy", busy, m_run || m_drain);
            check("done", done, m_done);
            check("inj_count", inj_count, m_cnt);
            if (m_ov) begin
                check("out_code", out_code, m_code);
                check("out_inj", out_inj, m_inj);
                check("out_idx", out_idx, m_oidx);
            end
        end
    end

    // Capture of output handshakes and done pulses for the directed literal checks
    int         cyc = 0, cap_n = 0, done_cnt = 0, hs_cyc = 0, done_cyc = 0;
    bit         any_ready = 0;
    logic [6:0] cap_code [32];
    logic       cap_inj  [32];
    logic [1:0] cap_idx  [32];

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (out_valid && out_ready && cap_n < 32) begin
            cap_code[cap_n] = out_code;
            cap_inj[cap_n]  = out_inj;
            cap_idx[cap_n]  = out_idx;
            cap_n++;
            hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_ready) any_ready = 1;
    end

    int d0;

    task automatic tick();
        @(posedge clk);
        #2;
        if (m_accepted < 16) in_code = code_tab[m_accepted];
    endtask

    task automatic start_burst(input int mode, input int idx, input int period, input int len);
        cap_n = 0; any_ready = 0; d0 = done_cnt;
        cfg_mode = 2'(mode); cfg_idx = 2'(idx); cfg_period = 4'(period); cfg_len = BW'(len);
        in_valid = 1; out_ready = 1; start = 1;
        in_code = code_tab[0];
        tick();
        start = 0;
        // scramble config to show the latched copy is used
        cfg_mode = 2'b11; cfg_idx = 2'd3; cfg_period = 4'd7; cfg_len = 8'd1;
    endtask

    task automatic wait_done(input bit stall);
        bit timed_out = 1;
        for (int i = 0; i < 300; i++) begin
            if (stall) out_ready = !(i >= 3 && i < 6);
            tick();
            if (done_cnt > d0) begin
                timed_out = 0;
                break;
            end
        end
        check("burst_timeout", timed_out, 0);
        in_valid = 0; out_ready = 1;
        tick();
    endtask

    task automatic wait_acc(input int n);
        bit timed_out = 1;
        for (int i = 0; i < 100; i++) begin
            if (m_accepted >= n) begin
                timed_out = 0;
                break;
            end
            tick();
        end
        check("accept_timeout", timed_out, 0);
    endtask

    task automatic check_caps(input string name, input int n, input logic [6:0] ec[8],
                              input logic ei[8], input logic [1:0] ex[8]);
        check({name, "_count"}, cap_n, n);
        for (int i = 0; i < n && i < cap_n; i++) begin
            check($sformatf("%s_code%0d", name, i), cap_code[i], ec[i]);
            check($sformatf("%s_inj%0d", name, i), cap_inj[i], ei[i]);
            check($sformatf("%s_idx%0d", name, i), cap_idx[i], ex[i]);
        end
    endtask

    initial begin
        logic [6:0] ec[8];
        logic       ei[8];
        logic [1:0] ex[8];
        rstn = 0; start = 0; abort = 0; in_valid = 0; out_ready = 1; in_code = '0;
        cfg_mode = '0; cfg_idx = '0; cfg_period = '0; cfg_len = '0;
        for (int i = 0; i < 16; i++) code_tab[i] = '0;
        repeat (3) tick();
        rstn = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_inj_count", inj_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        chk_en = 1;
        tick();

        // 1: fixed idx 2, single word
        code_tab[0] = 7'b1010101;
        start_burst(1, 2, 1, 1);
        wait_done(0);
        ec[0] = 7'b1010001; ei[0] = 1; ex[0] = 2;
        check_caps("t1", 1, ec, ei, ex);
        check("t1_done_lat", done_cyc - hs_cyc, 1);
        check("t1_inj_count", inj_count, 1);

        // 2: sweep, period 1, five zero words
        for (int i = 0; i < 16; i++) code_tab[i] = '0;
        start_burst(2, 0, 1, 5);
        wait_done(0);
        ec = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h01, 7'h00, 7'h00, 7'h00};
        ei = '{1, 1, 1, 1, 1, 0, 0, 0};
        ex = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_caps("t2", 5, ec, ei, ex);
        check("t2_inj_count", inj_count, 5);

        // 3: fixed idx 0, period 3, six words
        start_burst(1, 0, 3, 6);
        wait_done(0);
        ec = '{7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 7'h01, 7'h00, 7'h00};
        ei = '{0, 0, 1, 0, 0, 1, 0, 0};
        ex = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_caps("t3", 6, ec, ei, ex);
        check("t3_inj_count", inj_count, 2);

        // 4: backpressure, fixed idx 1, period 2
        for (int i = 0; i < 6; i++) code_tab[i] = 7'(8'h11 * (i + 1));
        start_burst(1, 1, 2, 6);
        wait_done(1);
        ec = '{7'h11, 7'h20, 7'h33, 7'h46, 7'h55, 7'h64, 7'h00, 7'h00};
        ei = '{0, 1, 0, 1, 0, 1, 0, 0};
        ex = '{0, 1, 0, 1, 0, 1, 0, 0};
        check_caps("t4", 6, ec, ei, ex);
        check("t4_inj_count", inj_count, 3);

        // 5: zero-length burst
        start_burst(1, 0, 1, 0);
        in_valid = 1;
        repeat (5) tick();
        in_valid = 0;
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_in_ready_seen", any_ready, 0);
        check("t5_words", cap_n, 0);

        // 6: mode off, then abort, then reset mid-burst
        code_tab[0] = 7'h7F; code_tab[1] = 7'h2A; code_tab[2] = 7'h55; code_tab[3] = 7'h01;
        start_burst(0, 3, 1, 4);
        wait_done(0);
        ec = '{7'h7F, 7'h2A, 7'h55, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        ex = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_caps("t6", 4, ec, ei, ex);
        check("t6_inj_count", inj_count, 0);

        start_burst(1, 3, 1, 4);
        wait_acc(2);
        abort = 1;
        tick();
        abort = 0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_inj_count", inj_count, 2);
        repeat (4) tick();
        in_valid = 0;
        check("abort_no_done", done_cnt - d0, 0);

        start_burst(2, 0, 1, 10);
        wait_acc(3);
        rstn = 0;
        tick();
        @(negedge clk);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_code", out_code, 0);
        check("mrst_out_inj", out_inj, 0);
        check("mrst_out_idx", out_idx, 0);
        check("mrst_done", done, 0);
        check("mrst_busy", busy, 0);
        check("mrst_inj_count", inj_count, 0);
        rstn = 1; in_valid = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamm_inject_ctrl.md
Name: hamm_inject_ctrl

Overview:
- Burst sequencer for Hamming(7,4) fault-injection experiments.
- Accepts codewords over a valid/ready stream and decides per word whether to corrupt it and which data-region bit (0..3) to flip. Flips go through a single error-injection sub-module.
- Emits the result through a one-deep registered output stage, tagged with injection info, ready for the downstream decoder/checker.

Parameters:
- BURST_W, 8, width of burst length and injection counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a burst. Ignored unless idle.
- abort  in  1  terminates the burst and flushes the output stage.
- cfg_mode  in  2  00 off, 01 fixed index, 10 sweep, 11 treated as off.
- cfg_idx  in  2  bit index used in fixed mode.
- cfg_period  in  4  inject every Nth accepted word; 0 means never.
- cfg_len  in  BURST_W  number of words in the burst.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid and in_ready are both high.
- in_code  in  7  input codeword.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_code  out  7  output codeword, possibly corrupted.
- out_inj  out  1  1 if out_code carries an injected flip.
- out_idx  out  2  bit flipped; 0 when out_inj=0.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at normal burst completion.
- inj_count  out  BURST_W  injections in the current/last burst.

Behaviour:
- Reset (rstn=0 at clock edge):
  - state=IDLE.
  - out_valid, out_code, out_inj, out_idx, done, busy, inj_count all 0.
  - Internal counters cleared.
  - Reset mid-burst discards everything, including a held output word.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latch cfg_* into shadow registers; clear word counter k, period counter, sweep index (to 0) and inj_count.
  - If latched cfg_len=0: IDLE -> DONE directly. done pulses next cycle and no word is accepted.
  - RUN -> DRAIN when the cfg_len-th word is accepted.
  - DRAIN -> DONE when the output stage is empty, i.e. out_valid=0 or the last word is handshaken this cycle.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - busy=1 in RUN and DRAIN only.
- Handshake:
  - in_ready = (state==RUN) and (out_valid==0 or out_ready==1).
  - An accepted word appears on out_* the next cycle, so latency is 1 cycle.
  - While out_valid=1 and out_ready=0, out_* are held stable.
  - Full throughput of 1 word/cycle under continuous ready.
- Injection decision per accepted word:
  - Period counter p counts 0..cfg_period-1.
  - Inject when mode is fixed or sweep, cfg_period != 0, and p == cfg_period-1. p wraps to 0 afterwards.
  - Fixed mode: idx = latched cfg_idx.
  - Sweep mode: idx = sweep index, which starts at 0, advances only on injected words, and wraps 3 -> 0.
  - Injected: out_code = in_code with bit idx inverted (bits 6:4 never touched), out_inj=1, out_idx=idx.
  - Not injected: out_code = in_code, out_inj=0, out_idx=0.
  - inj_count increments on each injected accept and saturates at all-ones.
- abort:
  - Any state -> IDLE next cycle; out_valid cleared and no done pulse.
  - inj_count retains its value.
  - abort has priority over start and over a same-cycle handshake.
- Config inputs changed mid-burst have no effect until the next start.

Decomposition:
- Shared package holds:
  - mode encodings MODE_OFF, MODE_FIXED, MODE_SWEEP;
  - FSM state encodings;
  - codeword width 7;
  - index width 2.
- One sub-module: the existing error_inject block, instantiated once.
  - Fed in_code and {1'b0, idx}.
  - Its output is muxed against in_code by the inject decision, because the sub-module always flips one bit.

Test Plan:
1. Fixed mode, cfg_idx=2, cfg_period=1, cfg_len=1, in_code=7'b1010101 -> out_code=7'b1010001, out_inj=1, out_idx=2; done one cycle after the handshake; inj_count=1.
2. Sweep mode, period=1, len=5, in_code=7'h00 each word -> out_code sequence 01,02,04,08,01; out_idx 0,1,2,3,0; inj_count=5.
3. Fixed mode, idx=0, period=3, len=6, code=7'h00 -> only words 3 and 6 output 7'h01 with out_inj=1; others 7'h00; inj_count=2.
4. Backpressure: out_ready held low 3 cycles mid-burst -> out_code/out_inj/out_idx stable and in_ready=0 throughout; no word lost or duplicated after release.
5. cfg_len=0 with start -> in_ready never asserted; done pulse once.
6. Mode off, len=4 -> 4 unmodified words and inj_count=0. Then abort after the 2nd accept -> IDLE next cycle, out_valid=0, no done. Then rstn low mid-burst -> all outputs 0.
